// File: rtl/input_fanout_layer_pkg.sv
// Shared definitions for the input fan-out layer: mode encoding and tap-mask sizing.
package input_fanout_layer_pkg;

  // Operating mode of the datapath; anything other than ModeTrain behaves as test.
  typedef enum logic {
    ModeTest  = 1'b0,
    ModeTrain = 1'b1
  } mode_e;

  // Tap mask holds one bit per state tap plus the internal training sink (top bit).
  function automatic int unsigned mask_width(input int unsigned nt);
    return nt + 1;
  endfunction

endpackage

// File: rtl/input_fanout_layer_sync_fifo.sv
// Single-clock valid/ready FIFO; the head entry is presented directly on the output side.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Ready depends only on occupancy, so a same-cycle pop never feeds back into ready.
  always_comb begin
    full      = (cnt_q == (AW + 1)'(DEPTH));
    empty     = (cnt_q == '0);
    in_ready  = !full && rst_n;
    out_valid = !empty;
    out_data  = mem_q[rd_ptr_q];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Storage array; contents are don't-care while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/input_fanout_layer.sv
// Input layer: buffers samples and forks each one to NT state taps, plus a training sink
// that joins with the weight and delta streams while in TRAIN mode.
module input_fanout_layer
  import input_fanout_layer_pkg::*;
#(
  parameter int unsigned NC    = 7,
  parameter int unsigned NN    = 6,
  parameter int unsigned WF    = 5,
  parameter int unsigned NT    = 2,
  parameter int unsigned DEPTH = 2,
  parameter string       BURST = "yes",
  parameter int unsigned CW    = 16
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iMode,
  input  logic                iValid_AM_Input,
  output logic                oReady_AM_Input,
  input  logic [NC*WF-1:0]    iData_AM_Input,
  output logic [NT-1:0]       oValid_BM_State,
  input  logic [NT-1:0]       iReady_BM_State,
  output logic [NT*NC*WF-1:0] oData_BM_State,
  input  logic                iValid_AS_Weight,
  output logic                oReady_AS_Weight,
  input  logic [NC*NN*WF-1:0] iData_AS_Weight,
  input  logic                iValid_AS_Delta0,
  output logic                oReady_AS_Delta0,
  input  logic [NN*WF-1:0]    iData_AS_Delta0,
  output logic [CW-1:0]       oCount_Train
);

  localparam int unsigned MW     = mask_width(NT);
  localparam int unsigned DW     = NC * WF;
  localparam bit          Bubble = (BURST == "no");

  logic          head_valid;
  logic [DW-1:0] head_data;
  logic          present;
  logic          retire;
  logic          sink_fire;
  logic [MW-1:0] mode_mask;
  logic [MW-1:0] eff_mask;
  logic [MW-1:0] tap_valid;
  logic [MW-1:0] tap_acc;
  logic [MW-1:0] tap_done;

  logic [MW-1:0] mask_q;
  logic          mask_held_q;
  logic [MW-1:0] sent_q;
  logic          bubble_q;
  logic [CW-1:0] count_q;

  // Weight and delta payloads are only consumed as tokens to pace training.
  logic unused_payload;
  assign unused_payload = ^{iData_AS_Weight, iData_AS_Delta0};

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (iCLK),
    .rst_n     (iRST),
    .in_valid  (iValid_AM_Input),
    .in_ready  (oReady_AM_Input),
    .in_data   (iData_AM_Input),
    .out_valid (head_valid),
    .out_ready (retire),
    .out_data  (head_data)
  );

  // Fork control: the mask is frozen from the first presented cycle until retire, so a
  // mode change mid-sample cannot withdraw a valid that is already asserted.
  always_comb begin
    mode_mask = (iMode == ModeTrain) ? '1 : MW'(1);
    eff_mask  = mask_held_q ? mask_q : mode_mask;
    present   = head_valid && !bubble_q;
    tap_valid = present ? (eff_mask & ~sent_q) : '0;
    sink_fire = tap_valid[NT] && iValid_AS_Weight && iValid_AS_Delta0;
    tap_acc   = {sink_fire, tap_valid[NT-1:0] & iReady_BM_State};
    tap_done  = ~eff_mask | sent_q | tap_acc;
    retire    = present && (&tap_done);
  end

  // Output drive; every tap carries the same head sample.
  always_comb begin
    oValid_BM_State  = tap_valid[NT-1:0];
    oData_BM_State   = {NT{head_data}};
    oReady_AS_Weight = sink_fire;
    oReady_AS_Delta0 = sink_fire;
    oCount_Train     = count_q;
  end

  // Per-sample fork state: sent flags, latched mask, post-retire bubble and train counter.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      mask_q      <= '0;
      mask_held_q <= 1'b0;
      sent_q      <= '0;
      bubble_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      if (present && !mask_held_q) begin
        mask_q <= mode_mask;
      end
      if (retire) begin
        mask_held_q <= 1'b0;
        sent_q      <= '0;
      end else begin
        if (present) begin
          mask_held_q <= 1'b1;
        end
        sent_q <= sent_q | tap_acc;
      end
      bubble_q <= Bubble && retire;
      if (retire && eff_mask[NT]) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_input_fanout_layer.sv
// Bench for input_fanout_layer: directed scenarios plus a random phase, all checked against a
// queue-based model of the sample stream and per-sample pending-tap sets.
module tb_input_fanout_layer;
  import input_fanout_layer_pkg::*;

  localparam int NC    = 7;
  localparam int NN    = 6;
  localparam int WF    = 5;
  localparam int NT    = 2;
  localparam int DEPTH = 2;
  localparam int CW    = 16;
  localparam int DW    = NC * WF;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                mode;
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       in_data;
  logic [NT-1:0]       st_valid;
  logic [NT-1:0]       st_ready;
  logic [NT*DW-1:0]    st_data;
  logic                w_valid;
  logic                w_ready;
  logic [NC*NN*WF-1:0] w_data;
  logic                d_valid;
  logic                d_ready;
  logic [NN*WF-1:0]    d_data;
  logic [CW-1:0]       count;

  logic [NT-1:0]       nb_valid;
  logic [CW-1:0]       nb_count;
  logic                nb_unused_in_ready;
  logic [NT*DW-1:0]    nb_unused_data;
  logic                nb_unused_w_ready;
  logic                nb_unused_d_ready;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [NT:0]   pend;
  bit            head_on;
  bit            train_req;
  logic [CW-1:0] mcount;

  always #5 clk = ~clk;

  input_fanout_layer #(
    .NC(NC), .NN(NN), .WF(WF), .NT(NT), .DEPTH(DEPTH), .BURST("yes"), .CW(CW)
  ) dut (
    .iCLK(clk), .iRST(rst_n), .iMode(mode),
    .iValid_AM_Input(in_valid), .oReady_AM_Input(in_ready), .iData_AM_Input(in_data),
    .oValid_BM_State(st_valid), .iReady_BM_State(st_ready), .oData_BM_State(st_data),
    .iValid_AS_Weight(w_valid), .oReady_AS_Weight(w_ready), .iData_AS_Weight(w_data),
    .iValid_AS_Delta0(d_valid), .oReady_AS_Delta0(d_ready), .iData_AS_Delta0(d_data),
    .oCount_Train(count)
  );

  input_fanout_layer #(
    .NC(NC), .NN(NN), .WF(WF), .NT(NT), .DEPTH(DEPTH), .BURST("no"), .CW(CW)
  ) dut_nb (
    .iCLK(clk), .iRST(rst_n), .iMode(mode),
    .iValid_AM_Input(in_valid), .oReady_AM_Input(nb_unused_in_ready), .iData_AM_Input(in_data),
    .oValid_BM_State(nb_valid), .iReady_BM_State(st_ready), .oData_BM_State(nb_unused_data),
    .iValid_AS_Weight(w_valid), .oReady_AS_Weight(nb_unused_w_ready), .iData_AS_Weight(w_data),
    .iValid_AS_Delta0(d_valid), .oReady_AS_Delta0(nb_unused_d_ready), .iData_AS_Delta0(d_data),
    .oCount_Train(nb_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs set; checks outputs, advances the model, returns at the
  // next posedge+1.
  task automatic step();
    bit            present;
    bit            ef;
    bit            eri;
    logic [NT-1:0] ev;
    logic [NT:0]   acc;
    #3;
    if (!rst_n) begin
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_valid", 128'(st_valid), 128'(0));
      chk("rst_w_ready", 128'(w_ready), 128'(0));
      chk("rst_d_ready", 128'(d_ready), 128'(0));
      chk("rst_count", 128'(count), 128'(0));
      mq.delete();
      pend    = '0;
      head_on = 0;
      mcount  = '0;
    end else begin
      present = (mq.size() > 0);
      if (present && !head_on) begin
        head_on   = 1;
        pend      = (mode == ModeTrain) ? {(NT + 1){1'b1}} : {{NT{1'b0}}, 1'b1};
        train_req = pend[NT];
      end
      ev  = present ? pend[NT-1:0] : '0;
      ef  = present && pend[NT] && w_valid && d_valid;
      eri = (mq.size() < DEPTH);
      chk("in_ready", 128'(in_ready), 128'(eri));
      chk("st_valid", 128'(st_valid), 128'(ev));
      chk("w_ready", 128'(w_ready), 128'(ef));
      chk("d_ready", 128'(d_ready), 128'(ef));
      chk("count", 128'(count), 128'(mcount));
      if (present) chk("st_data", 128'(st_data), 128'({NT{mq[0]}}));
      acc = {ef, ev & st_ready};
      if (present) begin
        pend = pend & ~acc;
        if (pend == '0) begin
          void'(mq.pop_front());
          head_on = 0;
          if (train_req) mcount = mcount + 1'b1;
        end
      end
      if (in_valid && eri) mq.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] sample;
    rst_n    = 1'b0;
    mode     = ModeTest;
    in_valid = 1'b1;
    in_data  = '0;
    st_ready = '1;
    w_valid  = 1'b1;
    d_valid  = 1'b1;
    w_data   = '0;
    d_data   = '0;
    pend     = '0;
    mcount   = '0;
    @(posedge clk);
    #1;

    // 1: reset held with input valid asserted
    repeat (3) step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();

    // 2: TEST mode single sample, only tap 0 fires
    mode     = ModeTest;
    in_data  = 35'h1234567;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #2;
    chk("t2_valid", 128'(st_valid), 128'(2'b01));
    chk("t2_w_ready", 128'(w_ready), 128'(0));
    step();
    step();
    #2;
    chk("t2_count", 128'(count), 128'(0));

    // 3: TRAIN mode, tap 1 stalled for 4 cycles
    mode     = ModeTrain;
    sample   = DW'({$urandom, $urandom});
    in_data  = sample;
    in_valid = 1'b1;
    st_ready = 2'b01;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) st_ready = 2'b11;
      #2;
      chk("t3_tap1_hold", 128'(st_valid[1]), 128'(1));
      chk("t3_tap0", 128'(st_valid[0]), 128'(i == 0));
      chk("t3_data_stable", 128'(st_data), 128'({NT{sample}}));
      step();
    end
    #2;
    chk("t3_count", 128'(count), 128'(1));

    // 4: delta stream stalled, FIFO fills, then drains
    d_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data  = DW'({$urandom, $urandom});
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2;
    chk("t4_full_ready", 128'(in_ready), 128'(0));
    chk("t4_w_stall", 128'(w_ready), 128'(0));
    d_valid = 1'b1;
    repeat (4) step();
    #2;
    chk("t4_count", 128'(count), 128'(1 + DEPTH));

    // 5: mode switch while tap 1 is still pending
    mode     = ModeTrain;
    st_ready = 2'b01;
    in_data  = DW'({$urandom, $urandom});
    in_valid = 1'b1;
    step();
    sample  = DW'({$urandom, $urandom});
    in_data = sample;
    #2;
    chk("t5_first_valid", 128'(st_valid), 128'(2'b11));
    step();
    in_valid = 1'b0;
    mode     = ModeTest;
    #2;
    chk("t5_tap1_pending", 128'(st_valid), 128'(2'b10));
    step();
    st_ready = 2'b11;
    #2;
    chk("t5_tap1_still", 128'(st_valid), 128'(2'b10));
    step();
    #2;
    chk("t5_next_tap0_only", 128'(st_valid), 128'(2'b01));
    chk("t5_next_data", 128'(st_data), 128'({NT{sample}}));
    step();

    // 6: burst vs bubble pacing from a clean reset
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    mode     = ModeTrain;
    st_ready = '1;
    w_valid  = 1'b1;
    d_valid  = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'({$urandom, $urandom});
    step();
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'({$urandom, $urandom});
      #2;
      chk("t6_nb_toggle", 128'(nb_valid[0]), 128'(i % 2));
      if (i <= 4) chk("t6_burst_high", 128'(st_valid[0]), 128'(1));
      step();
    end
    in_valid = 1'b0;
    #2;
    chk("t6_nb_count", 128'(nb_count), 128'(4));
    step();

    // Random phase
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DW'({$urandom, $urandom});
      st_ready = NT'($urandom);
      w_valid  = ($urandom_range(0, 9) < 7);
      d_valid  = ($urandom_range(0, 9) < 7);
      w_data   = (NC*NN*WF)'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                              $urandom});
      d_data   = (NN*WF)'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
